modport_uart: RTL and testbench

- APB-slave UART transceiver (8N1, optional parity) that sits between the APB peripheral bus and the serial pins of the UART environment.
- Serial output pin is Tx; serial input pin is RX.
- The serial side is driven and sampled synchronously to PCLK.
- Software loads bytes to transmit, reads received bytes and status, and sets the bit period through a small register map.

---
 rtl/modport_uart.sv | 194 +++++++++++++++++++
 tb/tb_modport_uart.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/modport_uart.sv
// modport_uart: APB-slave UART (8N1) with the serial side clocked by PCLK.
// Define UART_PARITY_EN to add a parity bit; CTRL bit2 then selects odd parity.
module modport_uart #(
    parameter int DATA_BITS   = 8,
    parameter int DEFAULT_DIV = 16,
    parameter int DIV_W       = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        Tx,
    input  logic        RX
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic [DIV_W-1:0]     div_q, tx_div_q, tx_cnt_q, rx_div_q, rx_cnt_q;
    logic [2:0]           ctrl_q;
    logic [DATA_BITS-1:0] hold_q, tx_sh_q, rx_sh_q, rx_byte_q;
    logic [BW-1:0]        tx_bit_q, rx_bit_q;
    state_t               tx_st_q, rx_st_q;
    logic tx_q, tx_full_q, tx_par_q;
    logic rx_s1_q, rx_s2_q, rx_prev_q, rx_perr_q;
    logic rx_valid_q, overrun_q, frame_err_q, par_err_q;
    logic xfer, a_data, a_stat, a_div, a_ctrl, wr_data, rd_data, rd_stat;
    logic tx_end, tx_load, rx_end, rx_mid;
    logic [5:0] status;
    logic unused_bits;

    assign xfer    = PSEL & PENABLE;
    assign a_data  = PADDR[3:2] == 2'd0;
    assign a_stat  = PADDR[3:2] == 2'd1;
    assign a_div   = PADDR[3:2] == 2'd2;
    assign a_ctrl  = PADDR[3:2] == 2'd3;
    assign wr_data = xfer & PWRITE & a_data & ~tx_full_q;
    assign rd_data = xfer & ~PWRITE & a_data;
    assign rd_stat = xfer & ~PWRITE & a_stat;
    assign PREADY  = 1'b1;
    assign PSLVERR = xfer & PWRITE & ((a_data & tx_full_q) | a_stat);
    assign status  = {par_err_q, frame_err_q, overrun_q, rx_valid_q, tx_full_q, tx_st_q != IDLE};
    assign PRDATA  = (xfer && !PWRITE) ? (a_data ? 32'(rx_byte_q) : a_stat ? 32'(status) :
                     a_div ? 32'(div_q) : 32'(ctrl_q)) : '0;
    assign Tx          = tx_q;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:DIV_W]};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_q  <= DIV_W'(DEFAULT_DIV);
            ctrl_q <= 3'b011;
        end else if (xfer && PWRITE) begin
            if (a_div) div_q <= PWDATA[DIV_W-1:0] < DIV_W'(4) ? DIV_W'(4) : PWDATA[DIV_W-1:0];
            if (a_ctrl) ctrl_q <= {PWDATA[2] & PAR, PWDATA[1:0]};
        end
    end

    assign tx_end  = tx_cnt_q == tx_div_q - 1'b1;
    assign tx_load = tx_full_q & ctrl_q[0] & (tx_st_q == IDLE || (tx_st_q == STOP && tx_end));

    // A new frame may start straight out of STOP so queued bytes go back-to-back.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_st_q   <= IDLE;
            tx_q      <= 1'b1;
            tx_full_q <= 1'b0;
            hold_q    <= '0;
            tx_sh_q   <= '0;
            tx_div_q  <= DIV_W'(DEFAULT_DIV);
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_par_q  <= 1'b0;
        end else begin
            tx_cnt_q <= tx_end ? '0 : tx_cnt_q + 1'b1;
            if (wr_data) begin
                hold_q    <= PWDATA[DATA_BITS-1:0];
                tx_full_q <= 1'b1;
            end
            if (tx_load) begin
                tx_st_q   <= START;
                tx_q      <= 1'b0;
                tx_full_q <= 1'b0;
                tx_sh_q   <= hold_q;
                tx_div_q  <= div_q;
                tx_cnt_q  <= '0;
                tx_bit_q  <= '0;
                tx_par_q  <= ^hold_q ^ ctrl_q[2];
            end else if (tx_end) begin
                case (tx_st_q)
                    START: begin
                        tx_st_q <= DATA;
                        tx_q    <= tx_sh_q[0];
                    end
                    DATA: begin
                        if (tx_bit_q == LAST) begin
                            tx_st_q <= PAR ? PARITY : STOP;
                            tx_q    <= PAR ? tx_par_q : 1'b1;
                        end else begin
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_q     <= tx_sh_q[1];
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        tx_st_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                    STOP:    tx_st_q <= IDLE;
                    default: tx_st_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_end = rx_cnt_q == rx_div_q - 1'b1;
    assign rx_mid = rx_cnt_q == (rx_div_q >> 1) - 1'b1;

    // Sampling points sit mid-bit: half a period into START, then every full period.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_st_q     <= IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_div_q    <= DIV_W'(DEFAULT_DIV);
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_perr_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_cnt_q  <= rx_cnt_q + 1'b1;
            if (rd_data) rx_valid_q <= 1'b0;
            if (rd_stat) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
                par_err_q   <= 1'b0;
            end
            case (rx_st_q)
                IDLE: if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
                    rx_st_q   <= START;
                    rx_cnt_q  <= '0;
                    rx_div_q  <= div_q;
                    rx_bit_q  <= '0;
                    rx_perr_q <= 1'b0;
                end
                START: if (rx_mid) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= rx_s2_q ? IDLE : DATA;
                end
                DATA: if (rx_end) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                    if (rx_bit_q == LAST) rx_st_q <= PAR ? PARITY : STOP;
                end
                PARITY: if (rx_end) begin
                    rx_cnt_q  <= '0;
                    rx_perr_q <= (^rx_sh_q ^ rx_s2_q) != ctrl_q[2];
                    rx_st_q   <= STOP;
                end
                STOP: if (rx_end) begin
                    rx_st_q <= IDLE;
                    if (!rx_s2_q) frame_err_q <= 1'b1;
                    else if (rx_perr_q) par_err_q <= 1'b1;
                    else if (rx_valid_q && !rd_data) overrun_q <= 1'b1;
                    else begin
                        rx_byte_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                    end
                end
                default: rx_st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modport_uart.sv
// tb_modport_uart: directed APB/serial vectors for modport_uart with hand-computed expectations.
module tb_modport_uart;
`ifdef UART_PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;
    localparam int NB = PE ? 11 : 10;

    logic PCLK = 1'b0, PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, Tx, RX;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    int checks = 0, errors = 0;
    bit odd = 1'b0;

    modport_uart dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .Tx(Tx), .RX(RX)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic wr_chk(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string tag);
        logic err;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        cyc(1);
        PENABLE = 1'b1;
        @(negedge PCLK);
        err = PSLVERR;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk(tag, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        cyc(1);
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = PRDATA;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk(tag, d, exp);
    endtask

    // Entered 1ns after the load edge; checks the start bit, then each bit mid-period (DIV=8).
    task automatic tx_frame(input logic [7:0] d, input string tag);
        logic [10:0] f;
        f = PE ? {1'b1, ^d ^ odd, d, 1'b0} : {2'b11, d, 1'b0};
        chk({tag, "_start_edge"}, 32'(Tx), 0);
        cyc(4);
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(Tx), 32'(f[i]));
            if (i < NB - 1) cyc(8);
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input logic flip);
        RX = 1'b0;
        cyc(8);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            cyc(8);
        end
        if (PE) begin
            RX = ^d ^ odd ^ flip;
            cyc(8);
        end
        RX = stop;
        cyc(8);
        RX = 1'b1;
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; RX = 1'b1;
        cyc(3);
        PRESET = 1'b0;
        chk("rst_tx", 32'(Tx), 1);
        chk("rst_pready", 32'(PREADY), 1);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pslverr", 32'(PSLVERR), 0);
        rd_chk(A_DIV, 16, "rst_div");
        rd_chk(A_CTRL, 3, "rst_ctrl");
        rd_chk(A_STAT, 0, "rst_status");
        wr_chk(A_STAT, 32'h5, 1'b1, "status_wr_err");
        wr_chk(A_DIV, 32'h2, 1'b0, "div_wr_small");
        rd_chk(A_DIV, 4, "div_clamp");
        wr_chk(A_DIV, 32'h8, 1'b0, "div_wr8");
        rd_chk(A_DIV, 8, "div_8");

        wr_chk(A_DATA, 32'hA5, 1'b0, "tx_a5_wr");
        cyc(1);
        tx_frame(8'hA5, "tx_a5");
        rd_chk(A_STAT, 32'h1, "tx_busy_stop");
        cyc(1);
        rd_chk(A_STAT, 32'h0, "tx_busy_clear");
        chk("tx_idle_line", 32'(Tx), 1);

        wr_chk(A_DATA, 32'h11, 1'b0, "b2b_wr1");
        wr_chk(A_DATA, 32'h22, 1'b0, "b2b_wr2");
        wr_chk(A_DATA, 32'h33, 1'b1, "b2b_wr3_full");
        rd_chk(A_STAT, 32'h3, "b2b_status_full");
        cyc(8 * NB - 6);
        chk("b2b_stop", 32'(Tx), 1);
        cyc(1);
        tx_frame(8'h22, "b2b_f2");
        cyc(6);
        rd_chk(A_STAT, 32'h0, "b2b_dropped");

        rx_send(8'h3C, 1'b1, 1'b0);
        cyc(2);
        rd_chk(A_STAT, 32'h04, "rx_valid");
        rd_chk(A_DATA, 32'h3C, "rx_data");
        rd_chk(A_STAT, 32'h00, "rx_valid_clr");
        rx_send(8'h55, 1'b1, 1'b0);
        cyc(2);
        rx_send(8'h66, 1'b1, 1'b0);
        cyc(2);
        rd_chk(A_STAT, 32'h0C, "rx_overrun");
        rd_chk(A_STAT, 32'h04, "rx_overrun_clr");
        rd_chk(A_DATA, 32'h55, "rx_keep_old");
        RX = 1'b0;
        cyc(2);
        RX = 1'b1;
        cyc(20);
        rd_chk(A_STAT, 32'h00, "false_start");
        rd_chk(A_DATA, 32'h55, "false_start_byte");
        rx_send(8'h81, 1'b0, 1'b0);
        cyc(2);
        rd_chk(A_STAT, 32'h10, "frame_err");
        rd_chk(A_STAT, 32'h00, "frame_err_clr");

`ifdef UART_PARITY_EN
        wr_chk(A_CTRL, 32'h7, 1'b0, "ctrl_wr_odd");
        odd = 1'b1;
        rd_chk(A_CTRL, 32'h7, "ctrl_odd");
        wr_chk(A_DATA, 32'h01, 1'b0, "par_tx_wr");
        cyc(1);
        tx_frame(8'h01, "par_tx");
        cyc(6);
        rx_send(8'h01, 1'b1, 1'b1);
        cyc(2);
        rd_chk(A_STAT, 32'h20, "par_err");
        rx_send(8'h03, 1'b1, 1'b0);
        cyc(2);
        rd_chk(A_STAT, 32'h04, "par_ok");
        rd_chk(A_DATA, 32'h03, "par_ok_data");
`else
        wr_chk(A_CTRL, 32'h7, 1'b0, "ctrl_wr7");
        rd_chk(A_CTRL, 32'h3, "ctrl_no_par");
`endif

        wr_chk(A_DATA, 32'h00, 1'b0, "rst_mid_wr1");
        wr_chk(A_DATA, 32'hFF, 1'b0, "rst_mid_wr2");
        cyc(2);
        chk("rst_mid_tx_low", 32'(Tx), 0);
        PRESET = 1'b1;
        cyc(1);
        chk("rst_mid_tx_high", 32'(Tx), 1);
        PRESET = 1'b0;
        rd_chk(A_STAT, 32'h0, "rst_mid_status");
        rd_chk(A_DIV, 16, "rst_mid_div");
        cyc(20);
        chk("rst_mid_idle", 32'(Tx), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
